// File: rtl/u_pkg.sv
// Shared definitions for the unary (thermometer) encoder: count width,
// S1 payload layout and the reference encode function.
package u_pkg;

  // Upper bounds used to size package-level types; W must stay below MAX_W.
  localparam int MAX_W  = 256;
  localparam int MAX_CW = 9;

  function automatic int cw(input int w);
    return $clog2(w) + 1;
  endfunction

  typedef struct packed {
    logic [MAX_CW-1:0] count;
    logic              compliment;
    logic              range_ok;
  } s1_payload_t;

  // Bits at or above w are always zero, also in complement form.
  function automatic logic [MAX_W-1:0] unary_encode(input logic [MAX_CW-1:0] k,
                                                    input logic compl,
                                                    input int w);
    logic [MAX_W-1:0] code;
    code = '0;
    for (int j = 0; j < MAX_W; j++) begin
      if (j < w) code[j] = (j < int'(k)) ^ compl;
    end
    return code;
  endfunction

endpackage

// File: rtl/u_enc_stage.sv
// Valid/ready pipeline register; payload only loads while the stage can accept,
// so a stalled entry holds stable.
module u_enc_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  assign in_ready = !out_valid | out_ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/u_enc.sv
// Two-stage binary-to-thermometer encoder with valid/ready output and a sticky
// out-of-range error flag.
module u_enc
  import u_pkg::*;
#(
  parameter int W                     = 16,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1,
  localparam int CW                   = cw(W)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          i_valid,
  input  logic [CW-1:0] i_count,
  input  logic          i_compliment,
  output logic          o_ready,
  output logic          o_valid,
  output logic [W-1:0]  o_code,
  output logic          o_is_compliment,
  input  logic          i_ready,
  output logic          o_err,
  input  logic          i_err_clr
);

  s1_payload_t      s1_in;
  s1_payload_t      s1_q;
  logic             s1_valid;
  logic             s1_down_rdy;
  logic [W:0]       s2_in;
  logic [W:0]       s2_q;
  logic             s2_rdy;
  logic             err_set;
  logic [MAX_W-1:0] code_full;

  always_comb begin
    s1_in            = '0;
    s1_in.count      = MAX_CW'(i_count);
    s1_in.compliment = P_ADMIT_COMPLIMENT_EN & i_compliment;
    s1_in.range_ok   = (int'(i_count) < W);
  end

  // An out-of-range entry is discarded, so it never waits on S2.
  assign s1_down_rdy = s2_rdy | !s1_q.range_ok;

  u_enc_stage #(.DW($bits(s1_payload_t))) u_s1 (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (i_valid),
    .in_data   (s1_in),
    .in_ready  (o_ready),
    .out_valid (s1_valid),
    .out_data  (s1_q),
    .out_ready (s1_down_rdy)
  );

  assign code_full = unary_encode(s1_q.count, s1_q.compliment, W);
  assign s2_in     = {code_full[W-1:0], s1_q.compliment};

  generate
    if (W < MAX_W) begin : g_hi
      logic code_hi_unused;
      assign code_hi_unused = ^code_full[MAX_W-1:W];
    end
  endgenerate

  u_enc_stage #(.DW(W + 1)) u_s2 (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (s1_valid & s1_q.range_ok),
    .in_data   (s2_in),
    .in_ready  (s2_rdy),
    .out_valid (o_valid),
    .out_data  (s2_q),
    .out_ready (i_ready)
  );

  assign o_code          = s2_q[W:1];
  assign o_is_compliment = s2_q[0];

  // S1 holds a bad entry for exactly one cycle, so this pulses once per error.
  assign err_set = s1_valid & !s1_q.range_ok;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)           o_err <= 1'b0;
    else if (err_set)   o_err <= 1'b1;
    else if (i_err_clr) o_err <= 1'b0;
  end

endmodule

// File: tb/tb_u_enc.sv
// Directed bench for u_enc: table-driven streaming plus hand-written
// backpressure, error, reset and complement-disable sequences.
module tb_u_enc;

  logic        clk = 1'b0;
  logic        arst;
  logic        i_valid;
  logic [4:0]  i_count;
  logic        i_compliment;
  logic        i_ready;
  logic        i_err_clr;
  logic        o_ready, o_valid, o_is_compliment, o_err;
  logic [15:0] o_code;
  logic        d_ready, d_valid, d_is_compliment, d_err;
  logic [15:0] d_code;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  u_enc #(.W(16), .P_ADMIT_COMPLIMENT_EN(1'b1)) dut (
    .clk(clk), .arst(arst), .i_valid(i_valid), .i_count(i_count),
    .i_compliment(i_compliment), .o_ready(o_ready), .o_valid(o_valid),
    .o_code(o_code), .o_is_compliment(o_is_compliment), .i_ready(i_ready),
    .o_err(o_err), .i_err_clr(i_err_clr)
  );

  u_enc #(.W(16), .P_ADMIT_COMPLIMENT_EN(1'b0)) dut_nc (
    .clk(clk), .arst(arst), .i_valid(i_valid), .i_count(i_count),
    .i_compliment(i_compliment), .o_ready(d_ready), .o_valid(d_valid),
    .o_code(d_code), .o_is_compliment(d_is_compliment), .i_ready(i_ready),
    .o_err(d_err), .i_err_clr(i_err_clr)
  );

  typedef struct {
    logic [4:0]  k;
    logic        c;
    logic [15:0] code;
    logic        isc;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] k, input logic c);
    i_valid      = v;
    i_count      = k;
    i_compliment = c;
  endtask

  // Independent admission rule: normal form is 2^k-1 with k < 16.
  function automatic logic admitted(input logic [15:0] code, input logic isc);
    logic [15:0] n;
    n = isc ? ~code : code;
    return ((n & (n + 16'd1)) == 16'd0) && (n != 16'hFFFF);
  endfunction

  initial begin
    vecs[0] = '{k: 5'd0,  c: 1'b0, code: 16'h0000, isc: 1'b0};
    vecs[1] = '{k: 5'd15, c: 1'b1, code: 16'h8000, isc: 1'b1};
    vecs[2] = '{k: 5'd3,  c: 1'b1, code: 16'hFFF8, isc: 1'b1};
    vecs[3] = '{k: 5'd15, c: 1'b0, code: 16'h7FFF, isc: 1'b0};
    vecs[4] = '{k: 5'd1,  c: 1'b0, code: 16'h0001, isc: 1'b0};
    vecs[5] = '{k: 5'd8,  c: 1'b1, code: 16'hFF00, isc: 1'b1};

    arst = 1'b1; i_ready = 1'b1; i_err_clr = 1'b0;
    drive(1'b0, 5'd0, 1'b0);
    tick(); tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_code", 32'(o_code), 32'd0);
    chk("rst_isc", 32'(o_is_compliment), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    arst = 1'b0;
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);

    // single k=5 normal
    tick();
    drive(1'b1, 5'd5, 1'b0);
    tick();
    drive(1'b0, 5'd0, 1'b0);
    chk("t1_lat1_valid", 32'(o_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(o_valid), 32'd1);
    chk("t1_code", 32'(o_code), 32'h001F);
    chk("t1_isc", 32'(o_is_compliment), 32'd0);
    tick();
    chk("t1_single", 32'(o_valid), 32'd0);

    // back-to-back stream
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive(1'b1, vecs[i].k, vecs[i].c);
      else       drive(1'b0, 5'd0, 1'b0);
      tick();
      if (i >= 1) begin
        chk($sformatf("vec%0d_valid", i - 1), 32'(o_valid), 32'd1);
        chk($sformatf("vec%0d_code", i - 1), 32'(o_code), 32'(vecs[i-1].code));
        chk($sformatf("vec%0d_isc", i - 1), 32'(o_is_compliment), 32'(vecs[i-1].isc));
        chk($sformatf("vec%0d_admit", i - 1), 32'(admitted(o_code, o_is_compliment)), 32'd1);
      end
    end
    drive(1'b0, 5'd0, 1'b0);
    tick();
    chk("stream_drain", 32'(o_valid), 32'd0);

    // backpressure
    i_ready = 1'b0;
    drive(1'b1, 5'd2, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1);
    #1;
    chk("bp_ready_s2free", 32'(o_ready), 32'd1);
    tick();
    drive(1'b1, 5'd10, 1'b0);
    #1;
    chk("bp_ready_full", 32'(o_ready), 32'd0);
    chk("bp_a_valid", 32'(o_valid), 32'd1);
    chk("bp_a_code", 32'(o_code), 32'h0003);
    tick();
    chk("bp_hold_ready", 32'(o_ready), 32'd0);
    chk("bp_hold_code", 32'(o_code), 32'h0003);
    i_ready = 1'b1;
    #1;
    chk("bp_pass_ready", 32'(o_ready), 32'd1);
    tick();
    drive(1'b0, 5'd0, 1'b0);
    chk("bp_b_code", 32'(o_code), 32'hFF80);
    chk("bp_b_isc", 32'(o_is_compliment), 32'd1);
    tick();
    chk("bp_c_valid", 32'(o_valid), 32'd1);
    chk("bp_c_code", 32'(o_code), 32'h03FF);
    tick();
    chk("bp_empty", 32'(o_valid), 32'd0);

    // out-of-range and error flag
    drive(1'b1, 5'd16, 1'b0);
    tick();
    drive(1'b1, 5'd2, 1'b0);
    chk("err_pre", 32'(o_err), 32'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0);
    chk("err_set", 32'(o_err), 32'd1);
    chk("err_no_out", 32'(o_valid), 32'd0);
    tick();
    chk("err_next_valid", 32'(o_valid), 32'd1);
    chk("err_next_code", 32'(o_code), 32'h0003);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    chk("err_clr", 32'(o_err), 32'd0);
    drive(1'b1, 5'd20, 1'b0);
    tick();
    drive(1'b0, 5'd0, 1'b0);
    i_err_clr = 1'b1;
    tick();
    chk("err_set_wins", 32'(o_err), 32'd1);
    chk("err_drop", 32'(o_valid), 32'd0);
    tick();
    i_err_clr = 1'b0;
    chk("err_clr2", 32'(o_err), 32'd0);

    // reset with two entries in flight
    i_ready = 1'b0;
    drive(1'b1, 5'd17, 1'b0);
    tick();
    drive(1'b1, 5'd4, 1'b0);
    tick();
    drive(1'b1, 5'd9, 1'b0);
    tick();
    drive(1'b0, 5'd0, 1'b0);
    chk("ar_pre_valid", 32'(o_valid), 32'd1);
    chk("ar_pre_ready", 32'(o_ready), 32'd0);
    chk("ar_pre_err", 32'(o_err), 32'd1);
    #2 arst = 1'b1;
    #1;
    chk("ar_valid", 32'(o_valid), 32'd0);
    chk("ar_code", 32'(o_code), 32'd0);
    chk("ar_err", 32'(o_err), 32'd0);
    #2 arst = 1'b0;
    i_ready = 1'b1;
    tick();
    tick();
    chk("ar_no_stale", 32'(o_valid), 32'd0);

    // complement disabled instance
    drive(1'b1, 5'd4, 1'b1);
    tick();
    drive(1'b0, 5'd0, 1'b0);
    tick();
    chk("nc_valid", 32'(d_valid), 32'd1);
    chk("nc_code", 32'(d_code), 32'h000F);
    chk("nc_isc", 32'(d_is_compliment), 32'd0);
    chk("c_code", 32'(o_code), 32'hFFF0);
    chk("c_isc", 32'(o_is_compliment), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/u_enc.md
# u_enc

Pipelined binary-to-unary (thermometer) encoder. Converts a binary count into a W-bit unary code, or optionally its complement, and delivers it over a valid/ready stream. It is the producer-side counterpart of the unary admission checker: every code it emits passes admission with the same W and complement setting. It sits between a binary control source and any consumer of thermometer-coded vectors.

## Interface
- W, 16: code width in bits; W ≥ 2.
- P_ADMIT_COMPLIMENT_EN, 1: enables complement-form output. When 0, `i_compliment` is ignored and treated as 0.
- Derived: CW = $clog2(W) + 1, the count width. It can always express the out-of-range value W.

Ports:
- clk  in  1  clock.
- arst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  input count is valid.
- i_count  in  CW  binary count k.
- i_compliment  in  1  request complement form.
- o_ready  out  1  encoder accepts input this cycle.
- o_valid  out  1  output code is valid.
- o_code  out  W  unary code.
- o_is_compliment  out  1  `o_code` is complement form.
- i_ready  in  1  downstream accepts the output.
- o_err  out  1  sticky flag: an out-of-range count was received.
- i_err_clr  in  1  clears `o_err`.

## Operation
- **Legal range:** k ∈ [0, W−1].
  - Normal form: `o_code[j] = (j < k)`.
  - Complement form: `o_code = ~normal`.
  - k = 0 normal gives all zeros. k = 0 complement gives all ones.
- **Out of range (k ≥ W):**
  - The input is still accepted (handshake completes) and then dropped; nothing is emitted.
  - `o_err` sets on the cycle after acceptance.
- **`o_err` control:**
  - `i_err_clr` clears `o_err` on the next edge.
  - If an error is being set and `i_err_clr` is asserted in the same cycle, set wins.
- **Pipeline:** two register stages, each holding {valid, payload}.
  - S1 holds {count, compliment, range_ok}.
  - S2 holds {code, is_compliment}.
  - Decoding is combinational between S1 and S2.
- **Per-stage ready rule:** `stage_rdy = !stage_valid | downstream_rdy`.
  - `o_ready = s1_rdy`.
  - S2's downstream ready is `i_ready`.
  - An out-of-range entry in S1 always advances (it is discarded) and never occupies S2.
- **Output stability:** while `o_valid & !i_ready`, `o_code` and `o_is_compliment` hold stable.
- **No combinational paths:** none from `i_valid` or `i_count` to any output. `o_ready` depends combinationally on `i_ready` (no skid buffer).

## Timing
- **Reset values:** `o_valid` = 0, `o_code` = 0, `o_is_compliment` = 0, `o_err` = 0. `o_ready` = 1 once reset deasserts.
- **Latency:** input accepted at edge t appears with `o_valid` = 1 after edge t+1, provided S2 was free. Minimum latency is 2 cycles.
- **Throughput:** one code per cycle with `i_ready` held high.
- **Backpressure:**
  - With `i_ready` = 0, S2 fills and then S1 fills.
  - `o_ready` falls once both stages are valid. At most 2 entries are in flight.
- **Pass-through when full:** when both stages are full and `i_ready` rises, a new input may be accepted in the same cycle.
- **Reset mid-operation:** `arst` flushes both stages immediately. In-flight entries are lost and `o_err` clears.
- **Complement disabled:** with P_ADMIT_COMPLIMENT_EN = 0, `o_is_compliment` is constant 0.

## Structure
- **Package `u_pkg`:**
  - function `cw(W)` returning the count width.
  - typedef for the S1 payload struct {count, compliment, range_ok}.
  - function `unary_encode(k, compl, W)`, shared with testbench models.
- **Sub-module `u_enc_stage`:**
  - Parameterised-width valid/ready pipeline register with asynchronous active-high reset.
  - Instantiated twice (S1, S2).
  - S1's downstream ready is forced to 1 when its entry is out of range.
- **Top level:** decode logic, error flag, ports.

## Test plan
Unless stated, W = 16 and P_ADMIT_COMPLIMENT_EN = 1.

1. Send k = 5, normal, with `i_ready` = 1 → two cycles later `o_code` = 16'h001F, `o_is_compliment` = 0, single-cycle `o_valid`.
2. Stream k = 0, then k = 15 complement, then k = 3 complement, back-to-back → outputs on consecutive cycles: 16'h0000, 16'h8000, 16'hFFF8, all passing the admission checker.
3. Hold `i_ready` = 0 and offer 3 inputs → only 2 are accepted and `o_ready` goes to 0. Release `i_ready` → codes emerge in order and the third input is accepted the same cycle.
4. Send k = 16, then k = 2 → no output for k = 16, `o_err` = 1, then `o_code` = 16'h0003. Assert `i_err_clr` → `o_err` = 0 the next cycle. Assert `i_err_clr` in the same cycle as a new error → `o_err` stays 1.
5. Assert `arst` while 2 entries are in flight → `o_valid` = 0 and `o_code` = 0 immediately. No stale output after deassertion.
6. With P_ADMIT_COMPLIMENT_EN = 0, send k = 4 with `i_compliment` = 1 → `o_code` = 16'h000F, `o_is_compliment` = 0.
